// File: rtl/cpu_pkg.sv
// Shared CPU definitions: exception codes, CP0 register numbers, PC-select
// encodings and the exception sequencer state type.
package cpu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CODE_W = 5;
  localparam int unsigned ADDR_W = 5;

  localparam logic [CODE_W-1:0] EXC_INT = CODE_W'(0);
  localparam logic [CODE_W-1:0] EXC_RI  = CODE_W'(10);
  localparam logic [CODE_W-1:0] EXC_OV  = CODE_W'(12);

  localparam logic [ADDR_W-1:0] CP0_STATUS = ADDR_W'(12);
  localparam logic [ADDR_W-1:0] CP0_CAUSE  = ADDR_W'(13);
  localparam logic [ADDR_W-1:0] CP0_EPC    = ADDR_W'(14);

  typedef enum logic [1:0] {
    PCSEL_SEQ     = 2'b00,
    PCSEL_HANDLER = 2'b01,
    PCSEL_EPC     = 2'b10
  } pc_sel_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TAKE    = 2'd1,
    HANDLER = 2'd2,
    RETURN  = 2'd3
  } exc_state_e;

  // Fixed-priority encode: RI over Ov over Int.
  function automatic logic [CODE_W-1:0] exc_code_of(input logic [2:0] src);
    if (src[0])      return EXC_RI;
    else if (src[1]) return EXC_OV;
    else             return EXC_INT;
  endfunction

endpackage

// File: rtl/cp0_regs.sv
// Minimal CP0: Status (IE/EXL), Cause (ExcCode, live IP2) and EPC storage
// with MTC0 writes and a combinational read port.
module cp0_regs
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              mtc0_we,
  input  logic [ADDR_W-1:0] cp0_addr,
  input  logic [XLEN-1:0]   cp0_wdata,
  input  logic              exc_take,
  input  logic              epc_load,
  input  logic [XLEN-1:0]   exc_pc,
  input  logic [CODE_W-1:0] exc_code,
  input  logic              exl_clr,
  input  logic              ip2,
  output logic [XLEN-1:0]   cp0_rdata,
  output logic [XLEN-1:0]   epc,
  output logic              ie,
  output logic              exl
);

  logic              ie_q, ie_d;
  logic              exl_q, exl_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [XLEN-1:0]   epc_q, epc_d;

  // Hardware exception updates take precedence over same-cycle MTC0 data.
  always_comb begin
    ie_d   = ie_q;
    exl_d  = exl_q;
    code_d = code_q;
    epc_d  = epc_q;
    if (mtc0_we && cp0_addr == CP0_STATUS) begin
      ie_d  = cp0_wdata[0];
      exl_d = cp0_wdata[1];
    end
    if (mtc0_we && cp0_addr == CP0_EPC) epc_d = cp0_wdata;
    if (exc_take) begin
      exl_d  = 1'b1;
      code_d = exc_code;
    end
    if (epc_load) epc_d = exc_pc;
    if (exl_clr)  exl_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ie_q   <= 1'b0;
      exl_q  <= 1'b0;
      code_q <= '0;
      epc_q  <= '0;
    end else begin
      ie_q   <= ie_d;
      exl_q  <= exl_d;
      code_q <= code_d;
      epc_q  <= epc_d;
    end
  end

  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      CP0_STATUS: cp0_rdata = (XLEN'(exl_q) << 1) | XLEN'(ie_q);
      CP0_CAUSE:  cp0_rdata = (XLEN'(ip2) << 10) | (XLEN'(code_q) << 2);
      CP0_EPC:    cp0_rdata = epc_q;
      default:    cp0_rdata = '0;
    endcase
  end

  assign epc = epc_q;
  assign ie  = ie_q;
  assign exl = exl_q;

endmodule

// File: rtl/exception_ctrl.sv
// Exception/interrupt sequencer: arbitrates ExpSrc, drives PC redirect and
// flush from registered state, and counts taken exceptions.
module exception_ctrl
  import cpu_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = 32'h8000_0180
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [2:0]        ExpSrc,
  input  logic [XLEN-1:0]   PC,
  input  logic              Eret,
  input  logic              Cp0Write,
  input  logic [ADDR_W-1:0] Cp0Addr,
  input  logic [XLEN-1:0]   Cp0WData,
  output logic [XLEN-1:0]   Cp0RData,
  output logic [1:0]        PcSel,
  output logic [XLEN-1:0]   PcTarget,
  output logic              Flush,
  output logic [XLEN-1:0]   ExcCount
);

  exc_state_e      state_q, state_d;
  logic [XLEN-1:0] count_q, count_d;
  logic            take, epc_load, exl_clr;
  logic            sync_req, int_req;
  logic [XLEN-1:0] epc;
  logic            ie, exl;

  assign sync_req = ExpSrc[0] | ExpSrc[1];
  assign int_req  = ExpSrc[2] & ie & ~exl;

  always_comb begin
    state_d  = state_q;
    take     = 1'b0;
    epc_load = 1'b0;
    exl_clr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync_req || int_req) begin
          take     = 1'b1;
          epc_load = 1'b1;
          state_d  = TAKE;
        end
      end
      TAKE: state_d = HANDLER;
      HANDLER: begin
        // Nested synchronous faults keep the original EPC; interrupts stay masked.
        if (sync_req) begin
          take    = 1'b1;
          state_d = TAKE;
        end else if (Eret) begin
          exl_clr = 1'b1;
          state_d = RETURN;
        end
      end
      RETURN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    count_d = take ? count_q + XLEN'(1) : count_q;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Redirect outputs decode the state register only, never ExpSrc.
  always_comb begin
    PcSel    = PCSEL_SEQ;
    PcTarget = '0;
    Flush    = 1'b0;
    case (state_q)
      TAKE: begin
        PcSel    = PCSEL_HANDLER;
        PcTarget = HANDLER_ADDR;
        Flush    = 1'b1;
      end
      RETURN: begin
        PcSel    = PCSEL_EPC;
        PcTarget = epc;
      end
      default: ;
    endcase
  end

  assign ExcCount = count_q;

  cp0_regs u_cp0_regs (
    .clk       (Clock),
    .rst       (Reset),
    .mtc0_we   (Cp0Write),
    .cp0_addr  (Cp0Addr),
    .cp0_wdata (Cp0WData),
    .exc_take  (take),
    .epc_load  (epc_load),
    .exc_pc    (PC),
    .exc_code  (exc_code_of(ExpSrc)),
    .exl_clr   (exl_clr),
    .ip2       (ExpSrc[2]),
    .cp0_rdata (Cp0RData),
    .epc       (epc),
    .ie        (ie),
    .exl       (exl)
  );

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed bench for exception_ctrl: take, priority, masking, ERET return,
// nested faults, same-edge MTC0 and asynchronous reset.
module tb_exception_ctrl;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [2:0]  ExpSrc = '0;
  logic [31:0] PC = '0;
  logic        Eret = 1'b0;
  logic        Cp0Write = 1'b0;
  logic [4:0]  Cp0Addr = '0;
  logic [31:0] Cp0WData = '0;
  logic [31:0] Cp0RData;
  logic [1:0]  PcSel;
  logic [31:0] PcTarget;
  logic        Flush;
  logic [31:0] ExcCount;

  int checks = 0;
  int errors = 0;

  exception_ctrl dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .ExpSrc   (ExpSrc),
    .PC       (PC),
    .Eret     (Eret),
    .Cp0Write (Cp0Write),
    .Cp0Addr  (Cp0Addr),
    .Cp0WData (Cp0WData),
    .Cp0RData (Cp0RData),
    .PcSel    (PcSel),
    .PcTarget (PcTarget),
    .Flush    (Flush),
    .ExcCount (ExcCount)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled at the negedge.
  task automatic step();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic cp0_check(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    Cp0Addr = addr;
    #1;
    check(tag, Cp0RData, exp);
  endtask

  task automatic redirect_check(input string tag, input logic [1:0] sel,
                                input logic [31:0] tgt, input logic fl);
    check({tag, ".sel"}, 32'(PcSel), 32'(sel));
    check({tag, ".tgt"}, PcTarget, tgt);
    check({tag, ".flush"}, 32'(Flush), 32'(fl));
  endtask

  initial begin
    @(negedge Clock);
    Reset = 1'b0;
    redirect_check("reset", 2'b00, 32'h0, 1'b0);
    check("reset.count", ExcCount, 32'd0);

    // Overflow from IDLE
    PC = 32'h0040_0010; ExpSrc = 3'b010;
    step();
    ExpSrc = 3'b000;
    redirect_check("ov", 2'b01, 32'h8000_0180, 1'b1);
    cp0_check("ov.epc", 5'd14, 32'h0040_0010);
    cp0_check("ov.cause", 5'd13, 32'h0000_0030);
    cp0_check("ov.status", 5'd12, 32'h0000_0002);
    check("ov.count", ExcCount, 32'd1);
    step();
    redirect_check("ov.handler", 2'b00, 32'h0, 1'b0);

    // ERET round trip
    Eret = 1'b1;
    step();
    Eret = 1'b0;
    redirect_check("eret", 2'b10, 32'h0040_0010, 1'b0);
    cp0_check("eret.status", 5'd12, 32'h0000_0000);
    step();
    redirect_check("eret.idle", 2'b00, 32'h0, 1'b0);
    Eret = 1'b1;
    step();
    Eret = 1'b0;
    redirect_check("eret_in_idle", 2'b00, 32'h0, 1'b0);

    // Interrupt masked while IE=0
    ExpSrc = 3'b100;
    step();
    ExpSrc = 3'b000;
    redirect_check("int_masked", 2'b00, 32'h0, 1'b0);
    check("int_masked.count", ExcCount, 32'd1);

    // Enable IE, then take a held interrupt
    Cp0Write = 1'b1; Cp0Addr = 5'd12; Cp0WData = 32'h1;
    step();
    Cp0Write = 1'b0;
    cp0_check("ie_set", 5'd12, 32'h0000_0001);
    PC = 32'h0040_0020; ExpSrc = 3'b100;
    step();
    redirect_check("int", 2'b01, 32'h8000_0180, 1'b1);
    cp0_check("int.cause", 5'd13, 32'h0000_0400);
    check("int.count", ExcCount, 32'd2);
    step();
    step();
    redirect_check("int_held", 2'b00, 32'h0, 1'b0);
    check("int_held.count", ExcCount, 32'd2);
    ExpSrc = 3'b000;
    Eret = 1'b1;
    step();
    Eret = 1'b0;
    redirect_check("int.eret", 2'b10, 32'h0040_0020, 1'b0);
    step();

    // Nested synchronous fault inside handler
    PC = 32'h0040_0010; ExpSrc = 3'b010;
    step();
    ExpSrc = 3'b000;
    check("nest.count0", ExcCount, 32'd3);
    step();
    PC = 32'h8000_0184; ExpSrc = 3'b001; Eret = 1'b1;
    step();
    ExpSrc = 3'b000; Eret = 1'b0;
    redirect_check("nest", 2'b01, 32'h8000_0180, 1'b1);
    cp0_check("nest.epc", 5'd14, 32'h0040_0010);
    cp0_check("nest.cause", 5'd13, 32'h0000_0028);
    check("nest.count", ExcCount, 32'd4);
    step();
    Eret = 1'b1;
    step();
    Eret = 1'b0;
    redirect_check("nest.eret", 2'b10, 32'h0040_0010, 1'b0);
    step();

    // All sources at once with IE=1
    PC = 32'h0040_0030; ExpSrc = 3'b111;
    step();
    cp0_check("prio.cause", 5'd13, 32'h0000_0428);
    check("prio.count", ExcCount, 32'd5);
    ExpSrc = 3'b000;
    cp0_check("prio.cause_low", 5'd13, 32'h0000_0028);
    step();
    Eret = 1'b1;
    step();
    Eret = 1'b0;
    step();

    // Same-edge MTC0 Status/EPC vs exception
    PC = 32'h0040_0040; ExpSrc = 3'b010;
    Cp0Write = 1'b1; Cp0Addr = 5'd12; Cp0WData = 32'h0;
    step();
    Cp0WData = 32'hDEAD_BEEF; Cp0Addr = 5'd14;
    cp0_check("mtc0_vs_exc.status", 5'd12, 32'h0000_0002);
    check("mtc0_vs_exc.count", ExcCount, 32'd6);
    Cp0Write = 1'b0; ExpSrc = 3'b000;
    cp0_check("unmapped", 5'd3, 32'h0);
    step();
    Eret = 1'b1;
    step();
    Eret = 1'b0;
    step();
    PC = 32'h0040_0050; ExpSrc = 3'b001;
    Cp0Write = 1'b1; Cp0Addr = 5'd14; Cp0WData = 32'hDEAD_BEEF;
    step();
    Cp0Write = 1'b0; ExpSrc = 3'b000;
    cp0_check("mtc0_epc_vs_exc", 5'd14, 32'h0040_0050);

    // Asynchronous reset while in TAKE
    redirect_check("pre_reset", 2'b01, 32'h8000_0180, 1'b1);
    #2;
    Reset = 1'b1;
    #1;
    redirect_check("async_reset", 2'b00, 32'h0, 1'b0);
    check("async_reset.count", ExcCount, 32'd0);
    cp0_check("async_reset.status", 5'd12, 32'h0);
    cp0_check("async_reset.cause", 5'd13, 32'h0);
    cp0_check("async_reset.epc", 5'd14, 32'h0);
    @(negedge Clock);
    Reset = 1'b0;
    step();
    redirect_check("post_reset", 2'b00, 32'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exception_ctrl.md
# exception_ctrl

Exception/interrupt sequencer for the single-cycle CPU. Arbitrates the three `ExpSrc` exception sources and latches EPC/Cause/Status in a minimal CP0. Redirects the PC to the handler and back on ERET, and counts taken exceptions alongside the existing J/R/I/TotalCycles statistics. Sits between the datapath's PC-select mux and the control unit.

## Interface
- `HANDLER_ADDR`, default 32'h8000_0180: handler entry PC.
- `Clock`  in  1: sole clock; all state updates on posedge.
- `Reset`  in  1: asynchronous, active-high; forces all state to reset values.
- `ExpSrc`  in  3: per-cycle exception requests, sampled every posedge.
  - bit0: reserved/undefined instruction.
  - bit1: arithmetic overflow.
  - bit2: external interrupt (level).
- `PC`  in  32: PC of the instruction currently executing.
- `Eret`  in  1: current instruction is ERET.
- `Cp0Write`  in  1: MTC0 write enable.
- `Cp0Addr`  in  5: CP0 register number (12 Status, 13 Cause, 14 EPC).
- `Cp0WData`  in  32: MTC0 data.
- `Cp0RData`  out  32: combinational read of `Cp0Addr`; unmapped address reads 0.
- `PcSel`  out  2: 00 sequential/branch, 01 handler, 10 EPC.
- `PcTarget`  out  32: `HANDLER_ADDR` when `PcSel`=01, EPC when 10, else 0.
- `Flush`  out  1: squash current instruction's writeback/memory write.
- `ExcCount`  out  32: number of exceptions taken.

## Operation
- CP0 registers:
  - Status: bit0 IE, bit1 EXL; other bits read 0.
  - Cause: [6:2] ExcCode, bit10 IP2 = live `ExpSrc[2]`; other bits read 0.
  - EPC: 32 bits.
- Write permissions:
  - MTC0 to Status writes IE/EXL.
  - MTC0 to EPC writes EPC.
  - MTC0 to Cause is ignored.
- Priority and ExcCode:
  - bit0 → ExcCode 10 (RI), highest.
  - bit1 → 12 (Ov).
  - bit2 → 0 (Int), taken only if IE=1 and EXL=0.
- FSM states: IDLE, TAKE, HANDLER, RETURN.
  - IDLE: on a qualifying request, enter TAKE.
    - EPC←`PC`, Cause.ExcCode←code, EXL←1, ExcCount+1.
  - TAKE: drives `PcSel`=01, `Flush`=1; unconditionally enters HANDLER next cycle.
  - HANDLER: on a synchronous request (bit0/bit1), enter TAKE.
    - Cause updated, ExcCount+1, EPC unchanged.
    - Interrupts are masked in this state.
  - HANDLER: on `Eret` with no synchronous request, enter RETURN; EXL←0.
  - RETURN: drives `PcSel`=10, `PcTarget`=EPC, `Flush`=0; enters IDLE next cycle.
- `Eret` in IDLE is a no-op (no redirect, no state change).
- ExcCount wraps modulo 2^32.

## Timing
- Reset values: state IDLE, EPC 0, Cause.ExcCode 0, IE 0, EXL 0, `PcSel` 00, `PcTarget` 0, `Flush` 0, `ExcCount` 0.
- `PcSel`/`PcTarget`/`Flush` are decoded from registered state only. They never combinationally depend on `ExpSrc`.
- Latency: request sampled at edge N; redirect/flush asserted during cycle N..N+1, exactly one cycle.
- Return latency: `Eret` sampled at edge N; `PcSel`=10 for exactly one cycle.
- Simultaneous events:
  - Exception vs `Eret`: exception wins.
  - MTC0 Status vs exception, same edge: IE from write data, EXL forced 1.
  - MTC0 EPC vs exception, same edge: hardware EPC update wins.
  - Multiple `ExpSrc` bits: only the highest-priority code is recorded; one ExcCount increment.
- A request held across TAKE is ignored in TAKE. In HANDLER it re-triggers only if synchronous.
- Reset mid-TAKE/RETURN: outputs return to reset values immediately (asynchronous), with no partial redirect.

## Structure
- Shared package `cpu_pkg`:
  - ExcCode constants (EXC_INT=0, EXC_RI=10, EXC_OV=12).
  - CP0 addresses (12/13/14).
  - `PcSel` encodings.
  - FSM state enum.
- One sub-module, `cp0_regs`: Status/Cause/EPC storage, MTC0 write logic, combinational read mux. The FSM, priority encoder and counter stay in `exception_ctrl`.

## Test plan
- Reset: assert `Reset` mid-run → all outputs 0, `Cp0RData` 0 for addr 12/13/14, `ExcCount`=0.
- Overflow: `PC`=0x0040_0010, `ExpSrc`=3'b010 one cycle → next cycle `PcSel`=01, `PcTarget`=0x8000_0180, `Flush`=1; EPC=0x0040_0010; Cause=0x0000_0030; `ExcCount`=1.
- Priority: `ExpSrc`=3'b111, IE=1 → ExcCode 10 (Cause=0x0000_0428 while bit2 held), single `ExcCount` increment.
- Masking: IE=0 with `ExpSrc`=3'b100 → no redirect. Write Status=0x1 then hold bit2 → taken with ExcCode 0; held again in HANDLER → not re-taken.
- ERET round-trip: in HANDLER, `Eret`=1 → next cycle `PcSel`=10, `PcTarget`=EPC, EXL=0; then IDLE. `Eret` in IDLE → `PcSel` stays 00.
- Nested synchronous: in HANDLER, EPC=0x0040_0010, `PC`=0x8000_0184, `ExpSrc`=3'b001 → redirect again, EPC stays 0x0040_0010, ExcCode 10, `ExcCount` increments.
